// File: rtl/mem_arb_pkg.sv
// Shared types and widths for the fetch/data RAM arbiter.
// Optional partial-store read-modify-write is enabled with MEM_ARB_RMW_EN.
package mem_arb_pkg;
    localparam int XLEN   = 32;
    localparam int STRB_W = 4;

    typedef enum logic {
        IDLE,
        RMW_WRITE
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_FETCH,
        OWN_DATA
    } owner_t;
endpackage

// File: rtl/byte_merge.sv
// Combinational byte-lane merge: strobed lanes take new_word, others keep old_word.
module byte_merge
    import mem_arb_pkg::*;
(
    input  logic [XLEN-1:0]   old_word,
    input  logic [XLEN-1:0]   new_word,
    input  logic [STRB_W-1:0] strb,
    output logic [XLEN-1:0]   merged
);
    for (genvar b = 0; b < STRB_W; b++) begin : g_lane
        assign merged[b*8 +: 8] = strb[b] ? new_word[b*8 +: 8] : old_word[b*8 +: 8];
    end
endmodule

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter for instruction fetch and load/store with fetch anti-starvation.
// Define MEM_ARB_RMW_EN to build byte/halfword stores as read-modify-write.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int FETCH_MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req,
    input  logic [XLEN-1:0]   i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [XLEN-1:0]   i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [XLEN-1:0]   d_addr,
    input  logic [XLEN-1:0]   d_wdata,
    input  logic [STRB_W-1:0] d_wstrb,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [XLEN-1:0]   d_rdata,
    output logic              ram_we,
    output logic [XLEN-1:0]   ram_addr,
    output logic [XLEN-1:0]   ram_din,
    input  logic [XLEN-1:0]   ram_dout
);
    localparam logic [3:0] MAX_WAIT = 4'(FETCH_MAX_WAIT);

    state_t     state, state_nxt;
    owner_t     owner, owner_nxt;
    logic [3:0] starve_cnt, starve_nxt;
    logic       fetch_win, data_win;

`ifdef MEM_ARB_RMW_EN
    logic [XLEN-1:0]   rmw_addr, rmw_wdata, merged;
    logic [STRB_W-1:0] rmw_strb;

    // ram_dout during RMW_WRITE is the word read back by the granting cycle
    byte_merge u_merge (
        .old_word (ram_dout),
        .new_word (rmw_wdata),
        .strb     (rmw_strb),
        .merged   (merged)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rmw_addr  <= '0;
            rmw_wdata <= '0;
            rmw_strb  <= '0;
        end else if (state == IDLE && data_win) begin
            rmw_addr  <= d_addr;
            rmw_wdata <= d_wdata;
            rmw_strb  <= d_wstrb;
        end
    end
`endif

    assign fetch_win = i_req && (!d_req || starve_cnt == MAX_WAIT);
    assign data_win  = d_req && !fetch_win;

    always_comb begin
        state_nxt = state;
        owner_nxt = OWN_NONE;
        i_gnt     = 1'b0;
        d_gnt     = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_din   = '0;
        case (state)
            IDLE: begin
                if (fetch_win) begin
                    i_gnt     = 1'b1;
                    ram_addr  = i_addr;
                    owner_nxt = OWN_FETCH;
                end else if (data_win) begin
                    d_gnt    = 1'b1;
                    ram_addr = d_addr;
                    ram_din  = d_wdata;
                    if (!d_we) begin
                        owner_nxt = OWN_DATA;
`ifdef MEM_ARB_RMW_EN
                    end else if (d_wstrb == 4'hF) begin
                        ram_we = 1'b1;
                    end else if (d_wstrb != 4'h0) begin
                        state_nxt = RMW_WRITE;  // this cycle is the read half
                    end
`else
                    end else begin
                        ram_we = |d_wstrb;
                    end
`endif
                end
            end
`ifdef MEM_ARB_RMW_EN
            RMW_WRITE: begin
                ram_we    = 1'b1;
                ram_addr  = rmw_addr;
                ram_din   = merged;
                state_nxt = IDLE;
            end
`endif
            default: state_nxt = IDLE;
        endcase
        // reset must kill an in-flight write without waiting for a clock
        if (!rst_n) begin
            i_gnt  = 1'b0;
            d_gnt  = 1'b0;
            ram_we = 1'b0;
        end
    end

    always_comb begin
        if (i_req && !i_gnt)
            starve_nxt = (starve_cnt == MAX_WAIT) ? MAX_WAIT : starve_cnt + 4'd1;
        else
            starve_nxt = 4'd0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            owner      <= OWN_NONE;
            starve_cnt <= 4'd0;
        end else begin
            state      <= state_nxt;
            owner      <= owner_nxt;
            starve_cnt <= starve_nxt;
        end
    end

    assign i_rvalid = (owner == OWN_FETCH);
    assign d_rvalid = (owner == OWN_DATA);
    assign i_rdata  = i_rvalid ? ram_dout : '0;
    assign d_rdata  = d_rvalid ? ram_dout : '0;
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic
// checked against a word-array memory model and the arbitration rules.
module tb_mem_arbiter;
    localparam int MAXW = 4;
`ifdef MEM_ARB_RMW_EN
    localparam bit RMW = 1'b1;
`else
    localparam bit RMW = 1'b0;
`endif

    logic        clk, rst_n;
    logic        i_req, i_gnt, i_rvalid;
    logic [31:0] i_addr, i_rdata;
    logic        d_req, d_we, d_gnt, d_rvalid;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic [3:0]  d_wstrb;
    logic        ram_we;
    logic [31:0] ram_addr, ram_din, ram_dout;

    logic [31:0] mem     [0:1023];
    logic [31:0] ref_mem [0:1023];
    int checks = 0;
    int errors = 0;

    mem_arbiter #(.FETCH_MAX_WAIT(MAXW)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Registered-read RAM: read returns the pre-write contents of the same edge
    always @(posedge clk) begin
        ram_dout <= mem[ram_addr[11:2]];
        if (ram_we) mem[ram_addr[11:2]] = ram_din;
    end

    task automatic drive_idle();
        i_req = 1'b0; i_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_wstrb = '0;
    endtask

    task automatic idle(input int n);
        drive_idle();
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        i_req = 1'b1; i_addr = 32'h4;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h8; d_wdata = 32'h12345678; d_wstrb = 4'hF;
        #2;
        checks++; if (i_gnt !== 1'b0) begin errors++; $display("FAIL rst_i_gnt got %b exp 0", i_gnt); end
        checks++; if (d_gnt !== 1'b0) begin errors++; $display("FAIL rst_d_gnt got %b exp 0", d_gnt); end
        checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL rst_ram_we got %b exp 0", ram_we); end
        checks++; if (i_rvalid !== 1'b0 || d_rvalid !== 1'b0) begin errors++; $display("FAIL rst_rvalid got %b%b exp 00", i_rvalid, d_rvalid); end
        checks++; if (i_rdata !== 32'h0 || d_rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata got %h %h exp 0", i_rdata, d_rdata); end
        @(negedge clk);
        drive_idle();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_fetch_seq();
        for (int k = 0; k < 5; k++) begin
            if (k < 3) begin i_req = 1'b1; i_addr = 32'(k * 4); end
            else drive_idle();
            #2;
            if (k < 3) begin
                checks++; if (i_gnt !== 1'b1) begin errors++; $display("FAIL fetch_gnt[%0d] got %b exp 1", k, i_gnt); end
                checks++; if (ram_we !== 1'b0 || ram_addr !== 32'(k * 4)) begin errors++; $display("FAIL fetch_ram[%0d] got we=%b addr=%h exp we=0 addr=%h", k, ram_we, ram_addr, k * 4); end
            end
            if (k >= 1 && k <= 3) begin
                checks++; if (i_rvalid !== 1'b1 || i_rdata !== ref_mem[k-1]) begin errors++; $display("FAIL fetch_rdata[%0d] got v=%b %h exp v=1 %h", k, i_rvalid, i_rdata, ref_mem[k-1]); end
            end else begin
                checks++; if (i_rvalid !== 1'b0) begin errors++; $display("FAIL fetch_rvalid[%0d] got %b exp 0", k, i_rvalid); end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_starvation();
        logic exp_i;
        i_req = 1'b1; i_addr = 32'h44;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
        for (int c = 0; c < 10; c++) begin
            #2;
            exp_i = (c % (MAXW + 1)) == MAXW;
            checks++; if (i_gnt !== exp_i || d_gnt !== !exp_i) begin errors++; $display("FAIL starve_gnt[%0d] got i=%b d=%b exp i=%b d=%b", c, i_gnt, d_gnt, exp_i, !exp_i); end
            @(negedge clk);
        end
        idle(2);
    endtask

    task automatic test_partial_store();
        logic [31:0] exp_w;
        exp_w = RMW ? 32'h1122AB44 : 32'h0000AB00;
        mem[4] = 32'h11223344; ref_mem[4] = 32'h11223344;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h10; d_wdata = 32'h0000AB00; d_wstrb = 4'b0010;
        #2;
        checks++; if (d_gnt !== 1'b1) begin errors++; $display("FAIL pstore_gnt got %b exp 1", d_gnt); end
`ifdef MEM_ARB_RMW_EN
        checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL pstore_read_we got %b exp 0", ram_we); end
`else
        checks++; if (ram_we !== 1'b1 || ram_din !== 32'h0000AB00) begin errors++; $display("FAIL pstore_full_we got we=%b din=%h exp we=1 din=0000ab00", ram_we, ram_din); end
`endif
        @(negedge clk);
        drive_idle();
        #2;
`ifdef MEM_ARB_RMW_EN
        checks++; if (ram_we !== 1'b1 || ram_din !== 32'h1122AB44 || ram_addr[11:2] !== 10'd4) begin errors++; $display("FAIL pstore_write got we=%b din=%h addr=%h exp we=1 din=1122ab44 addr=10", ram_we, ram_din, ram_addr); end
`else
        checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL pstore_second_we got %b exp 0", ram_we); end
`endif
        checks++; if (d_gnt !== 1'b0) begin errors++; $display("FAIL pstore_second_gnt got %b exp 0", d_gnt); end
        @(negedge clk);
        ref_mem[4] = exp_w;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10;
        #2;
        checks++; if (d_gnt !== 1'b1) begin errors++; $display("FAIL pstore_load_gnt got %b exp 1", d_gnt); end
        @(negedge clk);
        drive_idle();
        #2;
        checks++; if (d_rvalid !== 1'b1 || d_rdata !== exp_w) begin errors++; $display("FAIL pstore_load got v=%b %h exp v=1 %h", d_rvalid, d_rdata, exp_w); end
        idle(2);
    endtask

    task automatic test_full_store_load();
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'hDEADBEEF; d_wstrb = 4'hF;
        #2;
        checks++; if (d_gnt !== 1'b1 || ram_we !== 1'b1 || ram_din !== 32'hDEADBEEF) begin errors++; $display("FAIL fstore got gnt=%b we=%b din=%h exp 1 1 deadbeef", d_gnt, ram_we, ram_din); end
        ref_mem[8] = 32'hDEADBEEF;
        @(negedge clk);
        d_we = 1'b0; d_wstrb = 4'h0;
        #2;
        checks++; if (d_gnt !== 1'b1 || ram_we !== 1'b0) begin errors++; $display("FAIL fload_gnt got gnt=%b we=%b exp 1 0", d_gnt, ram_we); end
        checks++; if (d_rvalid !== 1'b0) begin errors++; $display("FAIL fstore_rvalid got %b exp 0", d_rvalid); end
        @(negedge clk);
        drive_idle();
        #2;
        checks++; if (d_rvalid !== 1'b1 || d_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL fload_data got v=%b %h exp v=1 deadbeef", d_rvalid, d_rdata); end
        idle(2);
    endtask

    task automatic test_reset_mid_rmw();
        logic [31:0] old;
        old = mem[12];
        i_req = 1'b1; i_addr = 32'h0;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h30; d_wdata = 32'h000000FF; d_wstrb = 4'b0001;
`ifdef MEM_ARB_RMW_EN
        #2;
        checks++; if (d_gnt !== 1'b1) begin errors++; $display("FAIL rmwrst_gnt got %b exp 1", d_gnt); end
        @(negedge clk);
        drive_idle(); i_req = 1'b1;
        #1;
        checks++; if (ram_we !== 1'b1) begin errors++; $display("FAIL rmwrst_pre_we got %b exp 1", ram_we); end
`else
        #1;
`endif
        rst_n = 1'b0;
        #1;
        checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL rmwrst_we got %b exp 0", ram_we); end
        checks++; if (i_gnt !== 1'b0 || d_gnt !== 1'b0) begin errors++; $display("FAIL rmwrst_gnt0 got i=%b d=%b exp 0 0", i_gnt, d_gnt); end
        checks++; if (i_rvalid !== 1'b0 || d_rvalid !== 1'b0) begin errors++; $display("FAIL rmwrst_rvalid got %b%b exp 00", i_rvalid, d_rvalid); end
        @(negedge clk);
        drive_idle();
        checks++; if (mem[12] !== old) begin errors++; $display("FAIL rmwrst_mem got %h exp %h", mem[12], old); end
        rst_n = 1'b1;
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h30;
        #2;
        checks++; if (d_gnt !== 1'b1) begin errors++; $display("FAIL rmwrst_idle_gnt got %b exp 1", d_gnt); end
        @(negedge clk);
        drive_idle();
        #2;
        checks++; if (d_rvalid !== 1'b1 || d_rdata !== old) begin errors++; $display("FAIL rmwrst_load got v=%b %h exp v=1 %h", d_rvalid, d_rdata, old); end
        idle(2);
    endtask

    task automatic test_zero_strobe();
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h14; d_wdata = $urandom; d_wstrb = 4'h0;
        #2;
        checks++; if (d_gnt !== 1'b1 || ram_we !== 1'b0) begin errors++; $display("FAIL zstrb got gnt=%b we=%b exp 1 0", d_gnt, ram_we); end
        @(negedge clk);
        drive_idle();
        #2;
        checks++; if (d_gnt !== 1'b0 || ram_we !== 1'b0 || d_rvalid !== 1'b0) begin errors++; $display("FAIL zstrb_after got gnt=%b we=%b rv=%b exp 0 0 0", d_gnt, ram_we, d_rvalid); end
        checks++; if (mem[5] !== ref_mem[5]) begin errors++; $display("FAIL zstrb_mem got %h exp %h", mem[5], ref_mem[5]); end
        idle(2);
    endtask

    task automatic test_random();
        int deny = 0;
        bit busy = 1'b0;
        bit pi = 1'b0, pd = 1'b0, xi, xd;
        logic [31:0] ei = '0, ed = '0, w;
        drive_idle();
        repeat (400) begin
            if (!i_req && $urandom_range(0, 3) != 0) begin
                i_req = 1'b1; i_addr = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
            end
            if (!d_req && $urandom_range(0, 2) != 0) begin
                d_req = 1'b1; d_we = 1'($urandom_range(0, 1));
                d_addr = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
                d_wdata = $urandom;
                case ($urandom_range(0, 3))
                    0: d_wstrb = 4'hF;
                    1: d_wstrb = 4'h0;
                    default: d_wstrb = 4'($urandom_range(1, 14));
                endcase
            end
            #2;
            xi = !busy && i_req && (!d_req || deny == MAXW);
            xd = !busy && d_req && !xi;
            checks++; if (i_gnt !== xi || d_gnt !== xd) begin errors++; $display("FAIL rnd_gnt got i=%b d=%b exp i=%b d=%b", i_gnt, d_gnt, xi, xd); end
            checks++; if (i_rvalid !== pi || (pi && i_rdata !== ei)) begin errors++; $display("FAIL rnd_fetch got v=%b %h exp v=%b %h", i_rvalid, i_rdata, pi, ei); end
            checks++; if (d_rvalid !== pd || (pd && d_rdata !== ed)) begin errors++; $display("FAIL rnd_load got v=%b %h exp v=%b %h", d_rvalid, d_rdata, pd, ed); end
            pi = xi;
            if (xi) ei = ref_mem[i_addr[11:2]];
            pd = xd && !d_we;
            if (pd) ed = ref_mem[d_addr[11:2]];
            if (xd && d_we && d_wstrb != 4'h0) begin
                w = ref_mem[d_addr[11:2]];
                for (int b = 0; b < 4; b++)
                    if (d_wstrb[b] || !RMW) w[b*8 +: 8] = d_wdata[b*8 +: 8];
                ref_mem[d_addr[11:2]] = w;
            end
            busy = RMW && xd && d_we && d_wstrb != 4'hF && d_wstrb != 4'h0;
            deny = (i_req && !xi) ? ((deny == MAXW) ? MAXW : deny + 1) : 0;
            @(negedge clk);
            if (xi) i_req = 1'b0;
            if (xd) d_req = 1'b0;
        end
        idle(2);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem[i]     = 32'hA5000000 ^ (32'(i) * 32'h00010307);
            ref_mem[i] = 32'hA5000000 ^ (32'(i) * 32'h00010307);
        end
        rst_n = 1'b0;
        drive_idle();
        #1;
        test_reset();
        test_fetch_seq();
        idle(2);
        test_starvation();
        test_partial_store();
        test_full_store_load();
        test_reset_mid_rmw();
        test_zero_strobe();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port arbiter sharing the core's 4 KB word RAM between the instruction-fetch port and the load/store port of the RV32IM pipeline. Accepts one request per cycle, forwards it to the RAM's clocked read/write interface, and returns read data one cycle later. Data accesses win by default; a starvation counter guarantees fetch progress. Partial (byte/halfword) stores are built with read-modify-write on top of the word-only RAM.

## Interface
- FETCH_MAX_WAIT, 4: consecutive denied fetch cycles before fetch is forced to win (1..15)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- i_req  in  1  fetch read request
- i_addr  in  32  fetch byte address
- i_gnt  out  1  fetch request accepted this cycle
- i_rvalid  out  1  fetch read data valid
- i_rdata  out  32  fetch read data
- d_req  in  1  data request
- d_we  in  1  1 = store, 0 = load
- d_addr  in  32  data byte address
- d_wdata  in  32  store data, byte lanes aligned to address
- d_wstrb  in  4  store byte enables
- d_gnt  out  1  data request accepted this cycle
- d_rvalid  out  1  load data valid
- d_rdata  out  32  load data
- ram_we  out  1  RAM write enable
- ram_addr  out  32  RAM byte address (RAM decodes [11:2])
- ram_din  out  32  RAM write data
- ram_dout  in  32  RAM read data, registered, valid one cycle after address

## Operation
- States: IDLE, RMW_WRITE.
- IDLE winner: d_req, unless i_req and starve_cnt == FETCH_MAX_WAIT, then fetch. Only requester → it wins.
- Winner gets *_gnt=1 same cycle (combinational); ram_addr/ram_we/ram_din driven from winner.
- Load or fetch: ram_we=0; next cycle *_rvalid=1, *_rdata=ram_dout; rvalid owner registered.
- Full store (d_wstrb==4'hF): ram_we=1, ram_din=d_wdata; complete at grant, no rvalid.
- Partial store (d_wstrb != 4'hF, != 0): grant in IDLE with ram_we=0 (read), latch addr/wdata/wstrb, go RMW_WRITE. In RMW_WRITE: ram_din = per-byte merge (strobe lane ? latched wdata : ram_dout), ram_we=1, ram_addr=latched addr, both gnt=0; return IDLE.
- d_wstrb==0 store: granted, no RAM write, no rvalid.
- starve_cnt: increments (saturating at FETCH_MAX_WAIT) each cycle i_req=1 and i_gnt=0; clears on i_gnt or i_req=0.
- Requesters must hold req/addr/data stable until gnt.

## Timing
- Reset: state IDLE, i_gnt=d_gnt=0 (outputs gated off in reset), i_rvalid=d_rvalid=0, i_rdata=d_rdata=0, ram_we=0, starve_cnt=0.
- Read latency: gnt at cycle T, rvalid at T+1. Back-to-back reads: one grant per cycle, throughput 1/cycle.
- Partial store occupies 2 cycles; pending requests stall one cycle.
- Load issued in cycle after a store to same address returns stored data (RAM write precedes read).
- Reset asserted mid-RMW: write aborted, ram_we deasserted immediately, no partial update.
- rvalid is never withheld; requesters must accept it.

## Configuration
- MEM_ARB_RMW_EN defined: partial-store read-modify-write as above.
- Undefined: no RMW_WRITE state; every store with d_wstrb != 0 writes d_wdata as a full word in one cycle (strobes otherwise ignored).

## Structure
- Package mem_arb_pkg: state enum (IDLE, RMW_WRITE), owner enum (OWN_NONE, OWN_FETCH, OWN_DATA), width constants (XLEN=32, STRB_W=4).
- One sub-module: byte_merge (combinational 32-bit lane merge by 4-bit strobe), instantiated only under MEM_ARB_RMW_EN.

## Test plan
- Fetch only, addresses 0x0,0x4,0x8 consecutive -> i_gnt each cycle, i_rdata matches preloaded words one cycle later, i_rvalid 3 consecutive cycles.
- d_req and i_req held continuously, FETCH_MAX_WAIT=4 -> 4 data grants then 1 fetch grant, pattern repeats; starve_cnt never exceeds 4.
- Word 0x11223344 at 0x10, store d_wstrb=4'b0010 d_wdata=0x0000AB00 -> two-cycle RMW, ram_we only in 2nd cycle, subsequent load returns 0x1122AB44; with macro undefined returns 0x0000AB00.
- Full store 0xDEADBEEF to 0x20 followed next cycle by load 0x20 -> d_rvalid with 0xDEADBEEF.
- Assert rst_n low during RMW_WRITE -> ram_we low immediately, memory word unchanged, all gnt/rvalid 0, state IDLE after release.
- Store with d_wstrb=0 -> d_gnt for one cycle, ram_we never asserted, no d_rvalid.
